// File: rtl/aes_pkg.sv
// Shared AES constants, decryptor FSM encoding, Rcon table and GF(2^8) helpers (poly 0x11B).
package aes_pkg;

  localparam int unsigned KeyW = 256;
  localparam int unsigned BlkW = 128;
  localparam int unsigned CntW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StKexp,
    StReady,
    StRound,
    StHold
  } dec_state_e;

  // Entry i is the Rcon byte for the i-th rotating key-schedule step (entry 0 unused).
  localparam logic [7:0][7:0] RconTab = {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Inverse computed as a^254, which also maps 0 to 0 as the S-boxes require.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational: inverse affine map followed by GF inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] pre;

  assign pre    = rotl8(data_i, 1) ^ rotl8(data_i, 3) ^ rotl8(data_i, 6) ^ 8'h05;
  assign data_o = gf_inv(pre);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box (encrypt side), combinational: GF inverse followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] inv;

  assign inv    = gf_inv(data_i);
  assign data_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;

endmodule

// File: rtl/aes256_seq_decrypt.sv
// AES-256 iterative decryptor: 13-cycle key expansion, one round per clock, one block in flight.
// Defining AES256_DEC_ERR_EN adds the sticky key_err output.
module aes256_seq_decrypt
  import aes_pkg::*;
#(
  parameter int unsigned NR = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_load,
  input  logic [KeyW-1:0] key,
  output logic            key_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BlkW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BlkW-1:0] out_data
`ifdef AES256_DEC_ERR_EN
  ,
  output logic            key_err
`endif
);

  localparam int unsigned NumRk = NR + 1;

  dec_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [BlkW-1:0] blk_q;
  logic [BlkW-1:0] rk_q [NumRk];
  logic            key_ready_q, in_ready_q, out_valid_q;
  logic [BlkW-1:0] out_data_q;

  logic            key_accept;
  logic [BlkW-1:0] rk_prev2, rk_prev1, rk_new, rk_cur;
  logic [31:0]     sub_in, sub_out, ks_tmp;
  logic [31:0]     n0, n1, n2, n3;
  logic [7:0]      isr_b [16];
  logic [7:0]      isb_b [16];
  logic [7:0]      ark_b [16];
  logic [BlkW-1:0] imc, fin, round_out;

  assign key_accept = key_load & ((state_q == StIdle) | (state_q == StReady) |
                                  ((state_q == StHold) & out_ready));

  // Key schedule: rk[cnt] from rk[cnt-2] and rk[cnt-1]; even steps rotate and add Rcon.
  always_comb begin
    rk_prev2 = rk_q[cnt_q - CntW'(2)];
    rk_prev1 = rk_q[cnt_q - CntW'(1)];
    sub_in   = cnt_q[0] ? rk_prev1[31:0] : {rk_prev1[23:0], rk_prev1[31:24]};
    ks_tmp   = sub_out ^ (cnt_q[0] ? 32'h0 : {RconTab[cnt_q[3:1]], 24'h0});
    n0       = rk_prev2[127:96] ^ ks_tmp;
    n1       = rk_prev2[95:64]  ^ n0;
    n2       = rk_prev2[63:32]  ^ n1;
    n3       = rk_prev2[31:0]   ^ n2;
    rk_new   = {n0, n1, n2, n3};
  end

  for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
    aes_sbox u_sbox (
      .data_i(sub_in[8*i +: 8]),
      .data_o(sub_out[8*i +: 8])
    );
  end

  // InvShiftRows: byte (r,c) takes byte (r,c-r); byte 0 sits at bits 127:120.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_b[r + 4*c] = blk_q[BlkW-1-8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .data_i(isr_b[i]),
      .data_o(isb_b[i])
    );
  end

  always_comb begin
    rk_cur = rk_q[cnt_q];
    imc    = '0;
    fin    = '0;
    for (int i = 0; i < 16; i++) begin
      ark_b[i] = isb_b[i] ^ rk_cur[BlkW-1-8*i -: 8];
      fin[BlkW-1-8*i -: 8] = ark_b[i];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        imc[BlkW-1-8*(r + 4*c) -: 8] = gmul(ark_b[4*c + r], 8'h0e) ^
                                       gmul(ark_b[4*c + (r + 1) % 4], 8'h0b) ^
                                       gmul(ark_b[4*c + (r + 2) % 4], 8'h0d) ^
                                       gmul(ark_b[4*c + (r + 3) % 4], 8'h09);
      end
    end
    round_out = (cnt_q == '0) ? fin : imc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      blk_q       <= '0;
      key_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NumRk; i++) rk_q[i] <= '0;
    end else if (key_accept) begin
      rk_q[0]     <= key[KeyW-1 -: BlkW];
      rk_q[1]     <= key[BlkW-1:0];
      cnt_q       <= CntW'(2);
      state_q     <= StKexp;
      key_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StKexp: begin
          rk_q[cnt_q] <= rk_new;
          if (cnt_q == CntW'(NR)) begin
            state_q     <= StReady;
            cnt_q       <= '0;
            key_ready_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StReady: begin
          if (in_valid) begin
            blk_q      <= in_data ^ rk_q[NR];
            cnt_q      <= CntW'(NR - 1);
            state_q    <= StRound;
            in_ready_q <= 1'b0;
          end
        end
        StRound: begin
          blk_q <= round_out;
          if (cnt_q == '0) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            out_data_q  <= round_out;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q     <= StReady;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: ;  // StIdle only leaves through key_accept
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef AES256_DEC_ERR_EN
  logic key_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_err_q <= 1'b0;
    end else if ((in_valid & ~key_ready_q) |
                 (key_load & ((state_q == StKexp) | (state_q == StRound)))) begin
      key_err_q <= 1'b1;
    end else if (key_accept) begin
      key_err_q <= 1'b0;
    end
  end

  assign key_err = key_err_q;
`endif

endmodule

// File: tb/tb_aes256_seq_decrypt.sv
// Self-checking bench for aes256_seq_decrypt against a word-level FIPS-197 software model.
module tb_aes256_seq_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [255:0] key;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES256_DEC_ERR_EN
  logic         key_err;
`endif

  aes256_seq_decrypt #(.NR(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key      (key),
    .key_ready(key_ready),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef AES256_DEC_ERR_EN
    ,
    .key_err  (key_err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rk_m    [15];
  logic [127:0] blk, ct;
  logic [127:0] b2b     [8];
  logic [127:0] b2b_exp [8];
  int           sent, got, cyc, last_out;
  logic         acc, con;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box via generator-3 walk: p steps through all units, q tracks 1/p.
  task automatic init_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic void expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[127-8*(r+4*c) -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox_t[s[127-8*i -: 8]] : sbox_t[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = gb(s, r, c);
        else     o[127-8*(r+4*c) -: 8] = gb(s, r, (c+r)%4);
    return o;
  endfunction

  // Circulant matrix product; coef holds the first matrix row.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coef);
    logic [127:0] o;
    logic [7:0]   a;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a = 8'h00;
        for (int j = 0; j < 4; j++) a = a ^ gm(coef[31-8*((j-r+4)%4) -: 8], gb(s, j, c));
        o[127-8*(r+4*c) -: 8] = a;
      end
    return o;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_m[0];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (rnd < 14) s = mix(s, 32'h02030101);
      s = s ^ rk_m[rnd];
    end
    return s;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] c_in);
    logic [127:0] s;
    s = c_in ^ rk_m[14];
    for (int rnd = 13; rnd >= 0; rnd--) begin
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_m[rnd];
      if (rnd > 0) s = mix(s, 32'h0e0b0d09);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input string tag, input logic [255:0] k);
    expand(k);
    key = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 12) check_bit({tag, "_key_ready_kexp12"}, key_ready, 1'b0);
    end
    check_bit({tag, "_key_ready"}, key_ready, 1'b1);
    check_bit({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] c_in, input logic [127:0] exp,
                           input int hold, input int kl_at, input logic [255:0] bogus);
    int lat;
    check_bit({tag, "_in_ready_pre"}, in_ready, 1'b1);
    in_data  = c_in;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == kl_at) begin
        key      = bogus;
        key_load = 1'b1;
      end else begin
        key_load = 1'b0;
      end
      tick();
      lat++;
    end
    key_load = 1'b0;
    check_int({tag, "_latency"}, lat, 14);
    check_blk({tag, "_data"}, out_data, exp);
    check_bit({tag, "_in_ready_busy"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_blk($sformatf("%s_hold%0d_data", tag, i), out_data, exp);
      check_bit($sformatf("%s_hold%0d_valid", tag, i), out_valid, 1'b1);
      check_bit($sformatf("%s_hold%0d_in_ready", tag, i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_bit({tag, "_consumed"}, out_valid, 1'b0);
    check_bit({tag, "_in_ready_post"}, in_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    init_tables();
    rst = 1'b1;
    key_load = 1'b0;
    key = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check_bit("rst_key_ready", key_ready, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_blk("rst_out_data", out_data, '0);
    rst = 1'b0;
    tick();
    check_bit("idle_in_ready", in_ready, 1'b0);

    load_key("fips", 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    run_block("fips", 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 0, -1, '0);

    load_key("loop", 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19);
    ct = model_enc(128'h00112233445566778899aabbccddeeff);
    run_block("loop", ct, 128'h00112233445566778899aabbccddeeff, 0, -1, '0);

    blk = rnd128();
    run_block("bp", blk, model_dec(blk), 20, -1, '0);

    blk = rnd128();
    run_block("klr", blk, model_dec(blk), 0, 3, {rnd128(), rnd128()});
    check_bit("klr_key_ready", key_ready, 1'b1);
`ifdef AES256_DEC_ERR_EN
    check_bit("klr_key_err", key_err, 1'b1);
`endif
    blk = rnd128();
    run_block("klr_after", blk, model_dec(blk), 0, -1, '0);

    in_data  = rnd128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check_bit("mid_rst_out_valid", out_valid, 1'b0);
    check_blk("mid_rst_out_data", out_data, '0);
    tick();
    check_bit("mid_rst_key_ready", key_ready, 1'b0);
    check_bit("mid_rst_in_ready", in_ready, 1'b0);
    check_blk("mid_rst_out_data_edge", out_data, '0);
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) tick();
    check_bit("post_rst_in_ready", in_ready, 1'b0);
    check_bit("post_rst_key_ready", key_ready, 1'b0);
    check_bit("post_rst_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    load_key("post_rst", {rnd128(), rnd128()});

    for (int i = 0; i < 8; i++) begin
      b2b[i]     = rnd128();
      b2b_exp[i] = model_dec(b2b[i]);
    end
    sent = 0;
    got = 0;
    cyc = 0;
    last_out = 0;
    in_data = b2b[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 8 && cyc < 400) begin
      acc = in_valid & in_ready;
      con = out_valid & out_ready;
      if (con) begin
        check_blk($sformatf("b2b_data%0d", got), out_data, b2b_exp[got]);
        if (got > 0) check_int($sformatf("b2b_period%0d", got), cyc - last_out, 16);
        last_out = cyc;
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) in_data = b2b[sent];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_int("b2b_count", got, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
